// File: rtl/round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : round_robin_arbiter
// Description : Fair round-robin arbiter with a registered, valid/ready
//               handshaked grant. The priority pointer wraps over
//               0..SIZE-1, so SIZE does not have to be a power of two.
//               One grant can be accepted per cycle; when a grant is
//               accepted the next winner is registered on the same edge,
//               so there is no idle cycle between back-to-back grants.
//
// Ports       : clock        - rising-edge clock
//               resetn       - asynchronous active-low reset
//               requests     - per-requester request bits
//               grant        - one-hot grant, zero while grant_valid is low
//               grant_index  - binary index of the granted requester
//               grant_valid  - a grant is presented to the resource
//               grant_ready  - resource accepts the current grant
//               lock         - (only with ROUND_ROBIN_ARBITER_LOCK_EN) keep
//                              the pointer on the current requester at
//                              acceptance, for multi-beat bursts
//
// Options     : ROUND_ROBIN_ARBITER_LOCK_EN - adds the lock input
//
// Revision    : 1.0 - initial release
// ============================================================================
module round_robin_arbiter #(
   parameter int SIZE      = 4,
   parameter int SIZE_LOG2 = $clog2(SIZE)
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic [SIZE-1:0]      requests,
   output logic [SIZE-1:0]      grant,
   output logic [SIZE_LOG2-1:0] grant_index,
   output logic                 grant_valid,
   input  logic                 grant_ready
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
   ,
   input  logic                 lock
`endif
);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_GRANTED = 1'b1
   } state_t;

   localparam logic [SIZE_LOG2-1:0] c_LAST      = SIZE_LOG2'(SIZE - 1);
   localparam logic [SIZE_LOG2-1:0] c_ONE       = SIZE_LOG2'(1);
   localparam logic [SIZE_LOG2:0]   c_SIZE_WIDE = (SIZE_LOG2 + 1)'(SIZE);
   localparam logic [SIZE-1:0]      c_GRANT_ONE = SIZE'(1);

   // Scan requests starting at ptr, wrapping at SIZE (not at a power of
   // two). The sum is kept one bit wider so ptr+k never overflows before
   // the wrap is applied. Returns {found, winner_index}.
   function automatic logic [SIZE_LOG2:0] f_arbitrate(
      input logic [SIZE-1:0]      req,
      input logic [SIZE_LOG2-1:0] ptr
   );
      logic                 found;
      logic [SIZE_LOG2-1:0] win;
      logic [SIZE_LOG2:0]   sum;
      logic [SIZE_LOG2-1:0] idx;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < SIZE; k++) begin
         sum = {1'b0, ptr} + (SIZE_LOG2 + 1)'(k);
         if (sum >= c_SIZE_WIDE) begin
            sum = sum - c_SIZE_WIDE;
         end
         idx = sum[SIZE_LOG2-1:0];
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      return {found, win};
   endfunction

   state_t               r_state;
   logic [SIZE_LOG2-1:0] r_pointer;
   logic [SIZE_LOG2-1:0] r_grant_index;
   logic [SIZE-1:0]      r_grant;

   state_t               w_state_next;
   logic [SIZE_LOG2-1:0] w_pointer_next;
   logic [SIZE_LOG2-1:0] w_index_next;
   logic [SIZE-1:0]      w_grant_next;

   logic                 w_hold;
   logic [SIZE_LOG2-1:0] w_advance_pointer;
   logic [SIZE_LOG2-1:0] w_arb_pointer;
   logic [SIZE_LOG2:0]   w_arb_result;
   logic                 w_arb_found;
   logic [SIZE_LOG2-1:0] w_arb_win;
   logic [SIZE-1:0]      w_arb_onehot;

`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
   // Lock only sticks while the granted requester still asks for the
   // resource; otherwise normal rotation resumes.
   assign w_hold = lock && requests[r_grant_index];
`else
   assign w_hold = 1'b0;
`endif

   // Pointer value to adopt at acceptance. Holding the pointer on the
   // granted index makes the scan pick that requester again.
   assign w_advance_pointer = w_hold ? r_grant_index :
                              (r_grant_index == c_LAST) ? '0 :
                              r_grant_index + c_ONE;

   // In IDLE arbitrate from the stored pointer; while GRANTED the only
   // re-arbitration that matters is at acceptance, using the new pointer.
   assign w_arb_pointer = (r_state == ST_GRANTED) ? w_advance_pointer : r_pointer;
   assign w_arb_result  = f_arbitrate(requests, w_arb_pointer);
   assign w_arb_found   = w_arb_result[SIZE_LOG2];
   assign w_arb_win     = w_arb_result[SIZE_LOG2-1:0];
   assign w_arb_onehot  = c_GRANT_ONE << w_arb_win;

   always_comb begin
      w_state_next   = r_state;
      w_pointer_next = r_pointer;
      w_index_next   = r_grant_index;
      w_grant_next   = r_grant;
      case (r_state)
         ST_IDLE: begin
            if (w_arb_found) begin
               w_state_next = ST_GRANTED;
               w_index_next = w_arb_win;
               w_grant_next = w_arb_onehot;
            end
         end
         ST_GRANTED: begin
            // Without acceptance the grant holds, whatever requests do.
            if (grant_ready) begin
               w_pointer_next = w_advance_pointer;
               if (w_arb_found) begin
                  w_index_next = w_arb_win;
                  w_grant_next = w_arb_onehot;
               end else begin
                  w_state_next = ST_IDLE;
                  w_index_next = '0;
                  w_grant_next = '0;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_index_next = '0;
            w_grant_next = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state       <= ST_IDLE;
         r_pointer     <= '0;
         r_grant_index <= '0;
         r_grant       <= '0;
      end else begin
         r_state       <= w_state_next;
         r_pointer     <= w_pointer_next;
         r_grant_index <= w_index_next;
         r_grant       <= w_grant_next;
      end
   end

   assign grant_valid = (r_state == ST_GRANTED);
   assign grant_index = r_grant_index;
   assign grant       = r_grant;

endmodule
`default_nettype wire
